// File: rtl/register_op_sequencer_if.sv
// Command, register-bank drive and shadow read-back signals of the register op sequencer.
// slave: sequencer side; master: control-unit / bank side.
interface register_op_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int NREG  = 4,
  parameter int CNT_W = 4
);
  localparam int SEL_W = (NREG > 1) ? $clog2(NREG) : 1;

  logic             CmdValid;
  logic             CmdReady;
  logic [SEL_W-1:0] CmdReg;
  logic [1:0]       CmdOp;
  logic [WIDTH-1:0] CmdData;
  logic [CNT_W-1:0] CmdCount;
  logic [NREG-1:0]  RegE;
  logic [1:0]       FunSel;
  logic [WIDTH-1:0] I;
  logic             Busy;
  logic             Done;
  logic [SEL_W-1:0] RdSel;
  logic [WIDTH-1:0] RdData;

  modport master (
    output CmdValid, CmdReg, CmdOp, CmdData, CmdCount, RdSel,
    input  CmdReady, RegE, FunSel, I, Busy, Done, RdData
  );

  modport slave (
    input  CmdValid, CmdReg, CmdOp, CmdData, CmdCount, RdSel,
    output CmdReady, RegE, FunSel, I, Busy, Done, RdData
  );
endinterface

// File: rtl/register_op_sequencer.sv
// Issues FunSel micro-ops (dec/inc/load/clear) to a register bank, repeating each CmdCount+1
// times, and keeps a shadow copy of every register for combinational read-back.
module register_op_sequencer #(
  parameter int WIDTH = 16,
  parameter int NREG  = 4,
  parameter int CNT_W = 4
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  register_op_sequencer_if.slave bus
);
  localparam int SEL_W = (NREG > 1) ? $clog2(NREG) : 1;

  localparam logic [1:0] ST_INIT  = 2'b00;
  localparam logic [1:0] ST_IDLE  = 2'b01;
  localparam logic [1:0] ST_ISSUE = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;

  localparam logic [1:0] OP_DEC  = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_r;
  logic [SEL_W-1:0] reg_r;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] data_r;
  logic [CNT_W-1:0] remaining_r;
  logic [WIDTH-1:0] shadow_r [NREG];

  logic             accept_s;
  logic [WIDTH-1:0] cur_s;
  logic [WIDTH-1:0] next_s;
  logic [NREG-1:0]  rege_s;
  logic [1:0]       funsel_s;
  logic [WIDTH-1:0] i_s;
  logic             ready_s;
  logic             busy_s;
  logic             done_s;
  logic [WIDTH-1:0] rd_s;

  assign accept_s = (state_r == ST_IDLE) && bus.CmdValid;

  // Current shadow of the latched target register; an out-of-range index reads as zero.
  always_comb begin
    cur_s = ZERO_W;
    for (int i = 0; i < NREG; i++) begin
      cur_s = (reg_r == SEL_W'(i)) ? shadow_r[i] : cur_s;
    end
  end

  // Value the bank register will hold after this issue cycle.
  always_comb begin
    next_s = cur_s;
    case (op_r)
      OP_DEC:  next_s = cur_s - ONE_W;
      OP_INC:  next_s = cur_s + ONE_W;
      OP_LOAD: next_s = data_r;
      OP_CLR:  next_s = ZERO_W;
      default: next_s = cur_s;
    endcase
  end

  // Sequencer state, command latches and repeat counter.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r     <= ST_INIT;
      reg_r       <= {SEL_W{1'b0}};
      op_r        <= 2'b00;
      data_r      <= ZERO_W;
      remaining_r <= ZERO_C;
    end else begin
      case (state_r)
        ST_INIT: state_r <= ST_IDLE;
        ST_IDLE: begin
          if (accept_s) begin
            reg_r       <= bus.CmdReg;
            op_r        <= bus.CmdOp;
            data_r      <= bus.CmdData;
            remaining_r <= bus.CmdCount;
            state_r     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (remaining_r == ZERO_C) begin
            state_r <= ST_DONE;
          end else begin
            remaining_r <= remaining_r - ONE_C;
          end
        end
        ST_DONE: state_r <= ST_IDLE;
        default: state_r <= ST_INIT;
      endcase
    end
  end

  // Shadows follow the bank: cleared alongside it in INIT, updated on every issue edge.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NREG; i++) begin
        shadow_r[i] <= ZERO_W;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (state_r == ST_INIT) begin
          shadow_r[i] <= ZERO_W;
        end else if ((state_r == ST_ISSUE) && (reg_r == SEL_W'(i))) begin
          shadow_r[i] <= next_s;
        end
      end
    end
  end

  // Bank drive and handshake decoded from the registered state; forced quiet while in reset.
  always_comb begin
    rege_s   = {NREG{1'b0}};
    funsel_s = 2'b00;
    i_s      = ZERO_W;
    ready_s  = 1'b0;
    busy_s   = 1'b1;
    done_s   = 1'b0;
    if (!Reset_n) begin
      busy_s = 1'b1;
    end else begin
      case (state_r)
        ST_INIT: begin
          rege_s   = {NREG{1'b1}};
          funsel_s = OP_CLR;
        end
        ST_IDLE: begin
          ready_s = 1'b1;
          busy_s  = 1'b0;
        end
        ST_ISSUE: begin
          for (int i = 0; i < NREG; i++) begin
            rege_s[i] = (reg_r == SEL_W'(i));
          end
          funsel_s = op_r;
          i_s      = (op_r == OP_LOAD) ? data_r : ZERO_W;
        end
        ST_DONE: done_s = 1'b1;
        default: busy_s = 1'b1;
      endcase
    end
  end

  // Shadow read-back; selects beyond NREG return zero.
  always_comb begin
    rd_s = ZERO_W;
    for (int i = 0; i < NREG; i++) begin
      rd_s = (bus.RdSel == SEL_W'(i)) ? shadow_r[i] : rd_s;
    end
  end

  assign bus.RegE     = rege_s;
  assign bus.FunSel   = funsel_s;
  assign bus.I        = i_s;
  assign bus.CmdReady = ready_s;
  assign bus.Busy     = busy_s;
  assign bus.Done     = done_s;
  assign bus.RdData   = rd_s;
endmodule

// File: tb/tb_register_op_sequencer.sv
// Randomized self-checking bench: a FunSel register bank on the outputs plus a transaction-level
// model of register contents and per-command issue/Done timing.
module tb_register_op_sequencer;
  localparam int WIDTH = 16;
  localparam int NREG  = 4;
  localparam int CNT_W = 4;

  logic Clock   = 1'b0;
  logic Reset_n = 1'b0;
  logic mon_en  = 1'b0;
  int   n_cmp   = 0;
  int   n_err   = 0;

  logic [WIDTH-1:0] bank  [NREG];
  logic [WIDTH-1:0] model [NREG];

  register_op_sequencer_if #(.WIDTH(WIDTH), .NREG(NREG), .CNT_W(CNT_W)) bus ();

  register_op_sequencer #(.WIDTH(WIDTH), .NREG(NREG), .CNT_W(CNT_W)) dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus.slave)
  );

  always #10 Clock = ~Clock;

  // Register bank driven by the sequencer
  always @(posedge Clock) begin
    for (int i = 0; i < NREG; i++) begin
      if (bus.RegE[i]) begin
        case (bus.FunSel)
          2'b00:   bank[i] <= bank[i] - 16'd1;
          2'b01:   bank[i] <= bank[i] + 16'd1;
          2'b10:   bank[i] <= bus.I;
          default: bank[i] <= 16'd0;
        endcase
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Shadow read-back must always agree with the real bank
  always @(negedge Clock) begin
    #8;
    if (mon_en) chk("shadow_vs_bank", 32'(bus.RdData), 32'(bank[bus.RdSel]));
  end

  function automatic logic [WIDTH-1:0] apply_op(input logic [1:0] op, input logic [WIDTH-1:0] q,
                                                 input logic [WIDTH-1:0] d);
    case (op)
      2'b00:   return q - 16'd1;
      2'b01:   return q + 16'd1;
      2'b10:   return d;
      default: return 16'd0;
    endcase
  endfunction

  task automatic sweep_rd(input string tag);
    for (int i = 0; i < NREG; i++) begin
      bus.RdSel = 2'(i);
      #1;
      chk(tag, 32'(bus.RdData), 32'(model[i]));
    end
  endtask

  task automatic read_one(input string tag, input int r, input logic [WIDTH-1:0] exp);
    bus.RdSel = 2'(r);
    #1;
    chk(tag, 32'(bus.RdData), 32'(exp));
  endtask

  // Issue one command starting at a negedge; returns at the negedge of the following IDLE cycle
  task automatic run_cmd(input int r, input logic [1:0] op, input logic [WIDTH-1:0] d,
                         input int cnt, input bit keep);
    int waited;
    logic [WIDTH-1:0] exp_i;
    waited       = 0;
    bus.CmdValid = 1'b1;
    bus.CmdReg   = 2'(r);
    bus.CmdOp    = op;
    bus.CmdData  = d;
    bus.CmdCount = 4'(cnt);
    while (bus.CmdReady !== 1'b1 && waited < 20) begin
      @(negedge Clock);
      waited++;
    end
    chk("accept_wait", (waited < 20) ? 32'd1 : 32'd0, 32'd1);
    @(negedge Clock);
    if (keep) begin
      bus.CmdReg   = 2'($urandom_range(0, 3));
      bus.CmdOp    = 2'($urandom_range(0, 3));
      bus.CmdData  = 16'($urandom);
      bus.CmdCount = 4'($urandom_range(0, 15));
    end else begin
      bus.CmdValid = 1'b0;
    end
    exp_i = (op == 2'b10) ? d : 16'd0;
    for (int k = 0; k <= cnt; k++) begin
      chk("issue_rege", 32'(bus.RegE), 32'd1 << r);
      chk("issue_funsel", 32'(bus.FunSel), 32'(op));
      chk("issue_i", 32'(bus.I), 32'(exp_i));
      chk("issue_ready", 32'(bus.CmdReady), 32'd0);
      chk("issue_busy", 32'(bus.Busy), 32'd1);
      chk("issue_done", 32'(bus.Done), 32'd0);
      read_one("issue_rd", r, model[r]);
      model[r] = apply_op(op, model[r], d);
      @(negedge Clock);
    end
    chk("done_pulse", 32'(bus.Done), 32'd1);
    chk("done_rege", 32'(bus.RegE), 32'd0);
    chk("done_ready", 32'(bus.CmdReady), 32'd0);
    chk("done_busy", 32'(bus.Busy), 32'd1);
    sweep_rd("done_rd");
    @(negedge Clock);
    chk("idle_done", 32'(bus.Done), 32'd0);
    chk("idle_ready", 32'(bus.CmdReady), 32'd1);
    chk("idle_busy", 32'(bus.Busy), 32'd0);
    chk("idle_rege", 32'(bus.RegE), 32'd0);
  endtask

  initial begin
    bus.CmdValid = 1'b0;
    bus.CmdReg   = 2'd0;
    bus.CmdOp    = 2'd0;
    bus.CmdData  = 16'd0;
    bus.CmdCount = 4'd0;
    bus.RdSel    = 2'd0;
    for (int i = 0; i < NREG; i++) model[i] = 16'd0;

    // Reset state and INIT clear
    #1;
    chk("rst_rege", 32'(bus.RegE), 32'd0);
    chk("rst_funsel", 32'(bus.FunSel), 32'd0);
    chk("rst_i", 32'(bus.I), 32'd0);
    chk("rst_ready", 32'(bus.CmdReady), 32'd0);
    chk("rst_done", 32'(bus.Done), 32'd0);
    chk("rst_busy", 32'(bus.Busy), 32'd1);
    chk("rst_rd", 32'(bus.RdData), 32'd0);
    repeat (3) @(negedge Clock);
    Reset_n = 1'b1;
    #1;
    chk("init_rege", 32'(bus.RegE), 32'hF);
    chk("init_funsel", 32'(bus.FunSel), 32'd3);
    chk("init_busy", 32'(bus.Busy), 32'd1);
    chk("init_ready", 32'(bus.CmdReady), 32'd0);
    @(negedge Clock);
    chk("idle_after_init", 32'(bus.CmdReady), 32'd1);
    mon_en = 1'b1;
    sweep_rd("init_rd");

    // Directed scenarios
    run_cmd(2, 2'b10, 16'h1234, 0, 1'b0);
    read_one("t2_rd2", 2, 16'h1234);
    run_cmd(1, 2'b10, 16'hFFFE, 0, 1'b0);
    run_cmd(1, 2'b01, 16'h5555, 3, 1'b0);
    read_one("t3_rd1", 1, 16'h0002);
    run_cmd(0, 2'b00, 16'h0000, 0, 1'b0);
    read_one("t4_dec", 0, 16'hFFFF);
    run_cmd(0, 2'b11, 16'hABCD, 2, 1'b0);
    read_one("t4_clr", 0, 16'h0000);
    run_cmd(3, 2'b10, 16'h0F0F, 1, 1'b1);
    run_cmd(2, 2'b00, 16'h0000, 2, 1'b0);
    read_one("t5_rd3", 3, 16'h0F0F);
    read_one("t5_rd2", 2, 16'h1231);

    // Randomized commands, some back-to-back with CmdValid held high
    for (int n = 0; n < 40; n++) begin
      bit keep;
      keep = (n < 39) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_cmd(int'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 16'($urandom),
              int'($urandom_range(0, 15)), keep);
      if (!keep) begin
        repeat ($urandom_range(0, 2)) begin
          bus.CmdData = 16'($urandom);
          bus.RdSel   = 2'($urandom_range(0, 3));
          @(negedge Clock);
        end
      end
    end

    // Reset in the middle of a long increment
    bus.CmdValid = 1'b1;
    bus.CmdReg   = 2'd3;
    bus.CmdOp    = 2'b01;
    bus.CmdData  = 16'd0;
    bus.CmdCount = 4'd7;
    @(negedge Clock);
    bus.CmdValid = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    chk("t6_issue_rege", 32'(bus.RegE), 32'h8);
    #3;
    mon_en  = 1'b0;
    Reset_n = 1'b0;
    #1;
    chk("t6_rege", 32'(bus.RegE), 32'd0);
    chk("t6_funsel", 32'(bus.FunSel), 32'd0);
    chk("t6_ready", 32'(bus.CmdReady), 32'd0);
    chk("t6_busy", 32'(bus.Busy), 32'd1);
    chk("t6_rd", 32'(bus.RdData), 32'd0);
    repeat (3) begin
      @(negedge Clock);
      chk("t6_no_done", 32'(bus.Done), 32'd0);
    end
    Reset_n = 1'b1;
    for (int i = 0; i < NREG; i++) model[i] = 16'd0;
    #1;
    chk("t6_init_rege", 32'(bus.RegE), 32'hF);
    chk("t6_init_funsel", 32'(bus.FunSel), 32'd3);
    chk("t6_init_done", 32'(bus.Done), 32'd0);
    @(negedge Clock);
    chk("t6_idle_ready", 32'(bus.CmdReady), 32'd1);
    mon_en = 1'b1;
    sweep_rd("t6_rd");
    read_one("t6_rd3", 3, 16'h0000);
    run_cmd(3, 2'b01, 16'h0000, 1, 1'b0);
    read_one("t6_after", 3, 16'h0002);

    @(negedge Clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
